// File: rtl/ahb_default_slave.sv
// AHB default slave: two-cycle ERROR for NONSEQ/SEQ, zero-wait OKAY for IDLE/BUSY.
// Define AHB_DEFSLV_ERRLOG_EN to add the fault log (err_clr, err_addr, err_write, err_cnt).
module ahb_default_slave #(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic                      hready,
    output logic                      hreadyout,
    output logic [1:0]                hresp,
    output logic [AHB_DATA_WIDTH-1:0] hrdata
`ifdef AHB_DEFSLV_ERRLOG_EN
    ,
    input  logic                      err_clr,
    output logic [AHB_ADDR_WIDTH-1:0] err_addr,
    output logic                      err_write,
    output logic [ERR_CNT_WIDTH-1:0]  err_cnt
`endif
);

    localparam logic [1:0] IDLE_ST = 2'd0;
    localparam logic [1:0] ERR1_ST = 2'd1;
    localparam logic [1:0] ERR2_ST = 2'd2;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       qualify;
    logic       start_err;

    // htrans[1] set means NONSEQ or SEQ
    assign qualify   = hsel & hready & htrans[1];
    assign start_err = qualify & (state_q != ERR1_ST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_ST: if (qualify) state_d = ERR1_ST;
            ERR1_ST: state_d = ERR2_ST;
            ERR2_ST: state_d = qualify ? ERR1_ST : IDLE_ST;
            default: state_d = IDLE_ST;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= IDLE_ST;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode only the state register, so reset forces them immediately.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = RESP_OKAY;
        case (state_q)
            ERR1_ST: begin
                hreadyout = 1'b0;
                hresp     = RESP_ERROR;
            end
            ERR2_ST: begin
                hreadyout = 1'b1;
                hresp     = RESP_ERROR;
            end
            default: begin
                hreadyout = 1'b1;
                hresp     = RESP_OKAY;
            end
        endcase
    end

    assign hrdata = '0;

`ifdef AHB_DEFSLV_ERRLOG_EN
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            err_addr  <= '0;
            err_write <= 1'b0;
            err_cnt   <= '0;
        end else if (start_err) begin
            // A new fault outranks a coincident clear; the count restarts at one.
            err_addr  <= haddr;
            err_write <= hwrite;
            if (err_clr) begin
                err_cnt <= ERR_CNT_WIDTH'(1);
            end else if (!(&err_cnt)) begin
                err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end
        end else if (err_clr) begin
            err_addr  <= '0;
            err_write <= 1'b0;
            err_cnt   <= '0;
        end
    end
`else
    logic unused_in;
    assign unused_in = ^{haddr, hwrite, htrans[0], start_err, ERR_CNT_WIDTH[0]};
`endif

endmodule
